// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 constants and decoder state type.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_BAT   = 8'hAA;
  localparam logic [7:0] PS2_ACK   = 8'hFA;
  localparam logic [7:0] PS2_ECHO  = 8'hEE;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_ENTER = 8'h5A;

  // Bytes following E1 in the Pause sequence (E1 14 77 E1 F0 14 F0 77).
  localparam int unsigned PAUSE_SKIP_LEN = 7;

  typedef enum logic [2:0] {
    IDLE_ST,
    EXT_ST,
    BRK_ST,
    EXT_BRK_ST,
    SKIP_ST
  } dec_state_t;

endpackage

// File: rtl/move_key_decoder.sv
// PS/2 byte stream to held-key levels plus start pulse.
// Optional macro KEY_TIMEOUT_EN adds an idle timer that force-releases held keys.
module move_key_decoder
  import ps2_pkg::*;
#(
  parameter logic [7:0] R_CODE     = KEY_RIGHT,
  parameter bit         R_EXT      = 1'b1,
  parameter logic [7:0] L_CODE     = KEY_LEFT,
  parameter bit         L_EXT      = 1'b1,
  parameter logic [7:0] START_CODE = KEY_ENTER
`ifdef KEY_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 37_500_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       move_r_key,
  output logic       move_l_key,
  output logic       start_key,
  output logic       decode_err
);

  dec_state_t state, state_nx;
  logic [2:0] skip_cnt, skip_nx;
  logic       start_held, held_nx;
  logic       r_nx, l_nx, start_nx, err_nx;
  logic       code_en, code_ext, code_brk;
  logic       timeout_hit;

`ifdef KEY_TIMEOUT_EN
  logic [25:0] idle_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                idle_cnt <= '0;
    else if (din_valid)       idle_cnt <= '0;
    else if (idle_cnt != '1)  idle_cnt <= idle_cnt + 26'd1;
  end

  assign timeout_hit = !din_valid && (idle_cnt == 26'(TIMEOUT_CYCLES - 1)) &&
                       (move_r_key || move_l_key || start_held);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE_ST;
      skip_cnt   <= '0;
      start_held <= 1'b0;
      move_r_key <= 1'b0;
      move_l_key <= 1'b0;
      start_key  <= 1'b0;
      decode_err <= 1'b0;
    end else begin
      state      <= state_nx;
      skip_cnt   <= skip_nx;
      start_held <= held_nx;
      move_r_key <= r_nx;
      move_l_key <= l_nx;
      start_key  <= start_nx;
      decode_err <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    held_nx  = start_held;
    r_nx     = move_r_key;
    l_nx     = move_l_key;
    start_nx = 1'b0;
    err_nx   = 1'b0;
    code_en  = 1'b0;
    code_ext = 1'b0;
    code_brk = 1'b0;

    if (din_valid) begin
      if (din == PS2_ERR0 || din == PS2_ERR1) begin
        state_nx = IDLE_ST;
        r_nx     = 1'b0;
        l_nx     = 1'b0;
        held_nx  = 1'b0;
        err_nx   = 1'b1;
      end else begin
        unique case (state)
          IDLE_ST: begin
            if (din == PS2_EXT)        state_nx = EXT_ST;
            else if (din == PS2_BRK)   state_nx = BRK_ST;
            else if (din == PS2_PAUSE) begin
              state_nx = SKIP_ST;
              skip_nx  = 3'(PAUSE_SKIP_LEN);
            end else if (din != PS2_BAT && din != PS2_ACK && din != PS2_ECHO)
              code_en = 1'b1;
          end
          EXT_ST: begin
            if (din == PS2_BRK)      state_nx = EXT_BRK_ST;
            else if (din != PS2_EXT) begin
              code_en  = 1'b1;
              code_ext = 1'b1;
              state_nx = IDLE_ST;
            end
          end
          BRK_ST: begin
            if (din == PS2_EXT) state_nx = EXT_BRK_ST;
            else begin
              code_en  = 1'b1;
              code_brk = 1'b1;
              state_nx = IDLE_ST;
            end
          end
          EXT_BRK_ST: begin
            code_en  = 1'b1;
            code_ext = 1'b1;
            code_brk = 1'b1;
            state_nx = IDLE_ST;
          end
          SKIP_ST: begin
            skip_nx = skip_cnt - 3'd1;
            if (skip_cnt == 3'd1) state_nx = IDLE_ST;
          end
          default: state_nx = IDLE_ST;
        endcase

        if (code_en) begin
          if (din == R_CODE && code_ext == R_EXT) r_nx = !code_brk;
          if (din == L_CODE && code_ext == L_EXT) l_nx = !code_brk;
          // Held flag suppresses typematic repeats so only the first make pulses.
          if (din == START_CODE && !code_ext) begin
            if (code_brk) held_nx = 1'b0;
            else if (!start_held) begin
              held_nx  = 1'b1;
              start_nx = 1'b1;
            end
          end
        end
      end
    end

    if (timeout_hit) begin
      state_nx = IDLE_ST;
      r_nx     = 1'b0;
      l_nx     = 1'b0;
      held_nx  = 1'b0;
    end
  end

endmodule

// File: tb/tb_move_key_decoder.sv
// Randomized and directed bench for move_key_decoder against a prefix-set reference model.
module tb_move_key_decoder;
  import ps2_pkg::*;

  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din;
  logic       din_valid;
  logic       move_r_key, move_l_key, start_key, decode_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_start = 0;

  bit          m_r, m_l, m_held, m_start, m_err;
  bit          m_has_e, m_has_f;
  int unsigned m_skip, m_idle;

  always #5 clk = ~clk;

  move_key_decoder #(
    .R_CODE    (8'h74),
    .R_EXT     (1'b1),
    .L_CODE    (8'h6B),
    .L_EXT     (1'b1),
    .START_CODE(8'h5A)
`ifdef KEY_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TMO)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .move_r_key(move_r_key),
    .move_l_key(move_l_key),
    .start_key (start_key),
    .decode_err(decode_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_r = 0; m_l = 0; m_held = 0;
    m_has_e = 0; m_has_f = 0; m_skip = 0;
  endfunction

  function automatic void apply_code(input logic [7:0] b, input bit e, input bit f);
    if (b == 8'h74 && e) m_r = !f;
    if (b == 8'h6B && e) m_l = !f;
    if (b == 8'h5A && !e) begin
      if (f) m_held = 0;
      else if (!m_held) begin
        m_held  = 1;
        m_start = 1;
      end
    end
  endfunction

  // Prefix bytes collected as a set; a code byte consumes the set.
  function automatic void model_step(input bit v, input logic [7:0] b);
    m_start = 0;
    m_err   = 0;
    if (!v) begin
      m_idle++;
`ifdef KEY_TIMEOUT_EN
      if (m_idle == TMO && (m_r || m_l || m_held)) model_clear();
`endif
      return;
    end
    m_idle = 0;
    if (b == 8'h00 || b == 8'hFF) begin
      model_clear();
      m_err = 1;
      return;
    end
    if (m_skip > 0) begin
      m_skip--;
      return;
    end
    if (b == 8'hE0 && !(m_has_e && m_has_f)) m_has_e = 1;
    else if (b == 8'hF0 && !m_has_f) m_has_f = 1;
    else if (!m_has_e && !m_has_f && b == 8'hE1) m_skip = 7;
    else if (!m_has_e && !m_has_f && (b == 8'hAA || b == 8'hFA || b == 8'hEE)) begin
    end else begin
      apply_code(b, m_has_e, m_has_f);
      m_has_e = 0;
      m_has_f = 0;
    end
  endfunction

  task automatic check_outputs();
    check("move_r_key", move_r_key, m_r);
    check("move_l_key", move_l_key, m_l);
    check("start_key",  start_key,  m_start);
    check("decode_err", decode_err, m_err);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input bit v, input logic [7:0] b);
    din_valid = v;
    din       = v ? b : 8'($urandom);
    @(posedge clk);
    model_step(v, b);
    #1;
    check_outputs();
    if (start_key) n_start++;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    din_valid = 1'b0;
    #1;
    model_clear();
    m_start = 0;
    m_err   = 0;
    m_idle  = 0;
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h74, 8'h6B, 8'h5A, 8'h74,
                            8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF, 8'h12, 8'h6B};

  initial begin
    reset = 1'b1;
    din_valid = 1'b0;
    din = 8'h00;
    @(negedge clk);
    do_reset();

    // Right key make then extended break.
    send(8'hE0); send(8'h74);
    check("r_after_make", move_r_key, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("r_after_break", move_r_key, 1'b0);

    // Both keys held; non-extended 74 has no effect.
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74);
    send(8'h74);
    check("both_held", {move_l_key, move_r_key}, 2'b11);

    // Start key repeats give one pulse per press.
    n_start = 0;
    send(8'h5A); send(8'h5A); send(8'h5A);
    send(8'hF0); send(8'h5A);
    send(8'h5A);
    step(1'b0, 8'h00);
    check("start_pulses", n_start, 2);

    // Pause sequence is skipped entirely.
    do_reset();
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hE0); send(8'h74);
    check("r_after_pause", move_r_key, 1'b1);

    // Error byte clears keys and discards prefix.
    send(8'hE0); send(8'h6B);
    send(8'hFF);
    check("l_after_err", move_l_key, 1'b0);
    send(8'hF0); send(8'h5A);
    send(8'h5A);

    // Reset in the middle of E0 F0.
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0);
    do_reset();
    send(8'h74);
    check("r_after_midreset", move_r_key, 1'b0);

    // Idle timeout.
    send(8'hE0); send(8'h74);
    for (int unsigned i = 0; i < TMO + 5; i++) step(1'b0, 8'h00);
`ifdef KEY_TIMEOUT_EN
    check("r_after_timeout", move_r_key, 1'b0);
`else
    check("r_after_timeout", move_r_key, 1'b1);
`endif

    // Random byte stream with gaps.
    do_reset();
    for (int unsigned i = 0; i < 3000; i++) begin
      bit         v;
      logic [7:0] b;
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 13)];
      step(v, b);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
